// File: rtl/icgtn_bank_ctrl.sv
// icgtn_bank_ctrl
//   Bank of NCH negative-edge integrated clock gates sharing one clock (CLKN).
//   Each channel has its own enable and a turn-off hold-off counter. The gate
//   stays open for HOLD_CYC extra falling edges after its enable drops, so
//   bursty enables do not toggle the gate every few cycles.
//   TE opens every gate for scan. It does not disturb the channel FSMs.
//   Q[i] idles high while gated. Its low pulses are always full CLKN low phases.
module icgtn_bank_ctrl #(
    parameter int NCH      = 4,
    parameter int HOLD_CYC = 3,
    parameter int CNT_W    = 2
) (
    input  logic           CLKN,
    input  logic           RN,
    input  logic           TE,
    input  logic [NCH-1:0] E,
    output logic [NCH-1:0] Q,
    output logic [NCH-1:0] ACTIVE,
    output logic [NCH-1:0] HOLDING
);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Counter preload when entering HOLD. It is only used when HOLD_CYC > 0.
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;
        logic             en_q;
        logic             gate_en_l;

        // Per-channel OFF/ON/HOLD sequencer, updated on the falling edge of CLKN.
        // NOTE: state registers use non-blocking assignments so every channel
        // sees the pre-edge values within the same edge.
        always_ff @(negedge CLKN) begin
            if (!RN) begin
                state <= S_OFF;
                cnt   <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        if (E[i]) state <= S_ON;
                    end
                    S_ON: begin
                        if (!E[i]) begin
                            if (HOLD_CYC > 0) begin
                                state <= S_HOLD;
                                cnt   <= HOLD_LOAD;
                            end else begin
                                state <= S_OFF;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (E[i]) begin
                            // A re-rising enable wins over an expiring counter.
                            state <= S_ON;
                            cnt   <= '0;
                        end else if (cnt == '0) begin
                            state <= S_OFF;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= S_OFF;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign ACTIVE[i]  = (state != S_OFF);
        assign HOLDING[i] = (state == S_HOLD);
        assign en_q       = ACTIVE[i] | TE;

        // Glitch-free enable capture: transparent while CLKN is high, held while it is low.
        // NOTE: this latch is intentional. It is the only level-sensitive element.
        // It is not reset, because it reloads from the reset FSM state
        // on the first CLKN high phase.
        always_latch begin
            if (CLKN) gate_en_l <= en_q;
        end

        assign Q[i] = CLKN | ~gate_en_l;
    end

endmodule

// File: tb/tb_icgtn_bank_ctrl.sv
// tb_icgtn_bank_ctrl
//   Randomized and directed stimulus for icgtn_bank_ctrl. A reference model
//   tracks, per channel, how many falling edges have passed since the enable
//   was last seen high. A channel is active while that age is within the hold
//   window. A second instance checks the HOLD_CYC=0 / NCH=1 build.
//   Q is sampled early and late in every low phase to confirm full-width
//   pulses. It is also sampled in every high phase, where it must be high.
module tb_icgtn_bank_ctrl;

    localparam int NCH  = 4;
    localparam int HOLD = 3;
    localparam int HALF = 5;
    localparam int INF  = 1000;

    logic           CLKN = 1'b1;
    logic           RN   = 1'b0;
    logic           TE   = 1'b0;
    logic [NCH-1:0] E    = '0;
    logic [NCH-1:0] Q, ACTIVE, HOLDING;
    logic [0:0]     q0, a0, h0;

    int total = 0;
    int bad   = 0;

    // Model state: edges since the enable was last sampled high (INF = never / reset).
    int age [NCH];
    int age0;

    always #HALF CLKN = ~CLKN;

    icgtn_bank_ctrl #(.NCH(NCH), .HOLD_CYC(HOLD), .CNT_W(2)) dut (
        .CLKN(CLKN), .RN(RN), .TE(TE), .E(E),
        .Q(Q), .ACTIVE(ACTIVE), .HOLDING(HOLDING)
    );

    icgtn_bank_ctrl #(.NCH(1), .HOLD_CYC(0), .CNT_W(1)) dut0 (
        .CLKN(CLKN), .RN(RN), .TE(TE), .E(E[2:2]),
        .Q(q0), .ACTIVE(a0), .HOLDING(h0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] m_active();
        logic [NCH-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) r[i] = (age[i] <= HOLD);
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_holding();
        logic [NCH-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) r[i] = (age[i] > 0) && (age[i] <= HOLD);
        return r;
    endfunction

    // One full CLKN cycle: falling edge, low-phase checks, high-phase check.
    // Inputs are changed by the caller during the high phase after this returns.
    task automatic tick(input bit chk, input bit te_drop = 1'b0);
        logic [NCH-1:0] xq;
        logic           x0;
        @(negedge CLKN);
        // The latch captured (state after previous edge | TE) during the high phase.
        xq = ~(m_active() | {NCH{TE}});
        x0 = ~((age0 == 0) | TE);
        for (int i = 0; i < NCH; i++) begin
            if (!RN)                 age[i] = INF;
            else if (E[i])           age[i] = 0;
            else if (age[i] < INF)   age[i] = age[i] + 1;
        end
        if (!RN)                age0 = INF;
        else if (E[2])          age0 = 0;
        else if (age0 < INF)    age0 = age0 + 1;
        #2;
        if (chk) begin
            check("q_low_early", Q, xq);
            check("q0_low_early", q0, x0);
            check("active", ACTIVE, m_active());
            check("holding", HOLDING, m_holding());
            check("active0", a0, age0 == 0);
            check("holding0", h0, 1'b0);
        end
        if (te_drop) TE = 1'b0;
        #2;
        if (chk) begin
            check("q_low_late", Q, xq);
            check("q0_low_late", q0, x0);
        end
        @(posedge CLKN);
        #1;
        if (chk) begin
            check("q_high", Q, {NCH{1'b1}});
            check("q0_high", q0, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) age[i] = INF;
        age0 = INF;

        // Reset with all enables high: everything stays gated.
        RN = 1'b0; TE = 1'b0; E = '1;
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);

        // Single-cycle enable on ch0: four low pulses, three HOLD cycles.
        RN = 1'b1; E = '0;
        tick(1'b1);
        E = 4'b0001;
        tick(1'b1);
        E = '0;
        repeat (6) tick(1'b1);

        // ch1 enable 1,0,0,1: HOLD then back to ON without a gap.
        E = 4'b0010; tick(1'b1);
        E = '0;      tick(1'b1); tick(1'b1);
        E = 4'b0010; tick(1'b1);
        E = '0;      repeat (5) tick(1'b1);

        // ch2 enable for two cycles (also drives the HOLD_CYC=0 instance).
        E = 4'b0100; tick(1'b1); tick(1'b1);
        E = '0;      repeat (3) tick(1'b1);

        // Scan: TE opens all gates during reset; drop TE mid low phase.
        TE = 1'b1; RN = 1'b0; E = '0;
        repeat (3) tick(1'b1);
        tick(1'b1, 1'b1);
        repeat (2) tick(1'b1);

        // Reset while ch3 is in HOLD with its counter at 2.
        RN = 1'b1; E = 4'b1000; tick(1'b1);
        E = '0;                 tick(1'b1);
        RN = 1'b0;              tick(1'b1);
        tick(1'b1);
        RN = 1'b1;              tick(1'b1);

        // Random sweep of enables, scan and reset.
        for (int n = 0; n < 400; n++) begin
            E  = NCH'($urandom);
            TE = ($urandom_range(0, 9) == 0);
            RN = ($urandom_range(0, 19) != 0);
            tick(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
